// File: rtl/tc_sram_mp.sv
// rtl/tc_sram_mp.sv - multi-port synchronous SRAM model with byte enables and read latency
module tc_sram_mp #(
  parameter int    NumWords    = 1024,
  parameter int    DataWidth   = 128,
  parameter int    ByteWidth   = 8,
  parameter int    NumPorts    = 2,
  parameter int    Latency     = 1,
  parameter string SimInit     = "none",
  parameter bit    PrintSimCfg = 1'b0,
  localparam int   AddrWidth   = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int   BeWidth     = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

  // Address space is exactly covered when NumWords is a power of two; no range check needed then.
  localparam bit FullRange  = (NumWords == (2 ** AddrWidth));
  localparam bit InitZeros  = (SimInit == "zeros");
  localparam bit InitOnes   = (SimInit == "ones");
  localparam bit InitRandom = (SimInit == "random");

  logic [DataWidth-1:0] mem [NumWords];
  logic [DataWidth-1:0] pipe [NumPorts][Latency];

  logic [NumPorts-1:0]                in_range;
  logic [NumPorts-1:0][DataWidth-1:0] wmask;

  // Parameter sanity and optional configuration banner, resolved at elaboration.
  if (Latency < 1) begin : g_bad_latency
    $error("tc_sram_mp: Latency must be >= 1");
  end
  if (NumPorts < 1) begin : g_bad_ports
    $error("tc_sram_mp: NumPorts must be >= 1");
  end
  if (NumWords < 1) begin : g_bad_words
    $error("tc_sram_mp: NumWords must be >= 1");
  end
  if (PrintSimCfg) begin : g_print_cfg
    $info("tc_sram_mp: NumWords=%0d DataWidth=%0d ByteWidth=%0d NumPorts=%0d Latency=%0d",
          NumWords, DataWidth, ByteWidth, NumPorts, Latency);
  end

  // Per-port address range flag and bit-level write mask expanded from the byte lanes.
  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    if (FullRange) begin : g_full
      assign in_range[p] = 1'b1;
    end else begin : g_part
      assign in_range[p] = (addr_i[p] < AddrWidth'(NumWords));
    end
    for (genvar i = 0; i < DataWidth; i++) begin : g_bit
      assign wmask[p][i] = be_i[p][i / ByteWidth];
    end
  end

  // Memory array: optional fill on reset, otherwise per-bit writes; later ports override earlier.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (InitZeros) begin
        for (int w = 0; w < NumWords; w++) mem[w] <= '0;
      end else if (InitOnes) begin
        for (int w = 0; w < NumWords; w++) mem[w] <= '1;
      end else if (InitRandom) begin
        for (int w = 0; w < NumWords; w++)
          for (int i = 0; i < DataWidth; i++) mem[w][i] <= 1'($urandom);
      end
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (req_i[p] && we_i[p] && in_range[p]) begin
          for (int i = 0; i < DataWidth; i++) begin
            if (wmask[p][i]) mem[addr_i[p]][i] <= wdata_i[p][i];
          end
        end
      end
    end
  end

  // Read pipeline: stage 0 captures pre-write memory contents on a read, later stages always shift.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumPorts; p++)
        for (int s = 0; s < Latency; s++) pipe[p][s] <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (req_i[p] && !we_i[p]) begin
          pipe[p][0] <= in_range[p] ? mem[addr_i[p]] : '0;
        end
        for (int s = 1; s < Latency; s++) pipe[p][s] <= pipe[p][s-1];
      end
    end
  end

  // Output is the final pipeline stage of each port.
  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NumPorts; p++) rdata_o[p] = pipe[p][Latency-1];
  end

  // Flag unknown request lines once out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!$isunknown(req_i)) else $error("tc_sram_mp: X on req_i");
    end
  end

endmodule

// File: tb/tb_tc_sram_mp.sv
// tb/tb_tc_sram_mp.sv - directed-vector bench for tc_sram_mp at latency 1 and latency 3
module tb_tc_sram_mp;

  localparam int NW = 12;
  localparam int DW = 32;
  localparam int NP = 2;
  localparam int AW = 4;
  localparam int BW = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NP-1:0]          req = '0;
  logic [NP-1:0]          we = '0;
  logic [NP-1:0][AW-1:0]  addr = '0;
  logic [NP-1:0][DW-1:0]  wdata = '0;
  logic [NP-1:0][BW-1:0]  be = '0;
  logic [NP-1:0][DW-1:0]  rdata_a;
  logic [NP-1:0][DW-1:0]  rdata_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  tc_sram_mp #(
    .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .NumPorts(NP),
    .Latency(1), .SimInit("zeros"), .PrintSimCfg(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata_a)
  );

  tc_sram_mp #(
    .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .NumPorts(NP),
    .Latency(3), .SimInit("none"), .PrintSimCfg(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata_b)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then release all requests for the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
    req = '0;
    we  = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [BW-1:0] b);
    req[p] = 1'b1; we[p] = 1'b1; addr[p] = a; wdata[p] = d; be[p] = b;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    req[p] = 1'b1; we[p] = 1'b0; addr[p] = a;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_a1", rdata_a[1], 32'h0);
    chk("reset_b1", rdata_b[1], 32'h0);

    rd(1, 4'd5); step();
    chk("zeros_rd5", rdata_a[1], 32'h0);

    wr(0, 4'd3, 32'hDEAD_BEEF, 4'hF); step();
    rd(1, 4'd3); step();
    chk("wr3_a_lat1", rdata_a[1], 32'hDEAD_BEEF);
    chk("wr3_b_early0", rdata_b[1], 32'h0);
    step();
    chk("wr3_a_hold", rdata_a[1], 32'hDEAD_BEEF);
    chk("wr3_b_early1", rdata_b[1], 32'h0);
    step();
    chk("wr3_a_hold2", rdata_a[1], 32'hDEAD_BEEF);
    chk("wr3_b_lat3", rdata_b[1], 32'hDEAD_BEEF);

    wr(0, 4'd4, 32'h1122_3344, 4'hF); step();
    wr(0, 4'd4, 32'hAABB_CCDD, 4'b0101); step();
    rd(1, 4'd4); step();
    chk("be_0101", rdata_a[1], 32'h11BB_33DD);
    wr(0, 4'd4, 32'hFFFF_FFFF, 4'b0000); step();
    rd(1, 4'd4); step();
    chk("be_none", rdata_a[1], 32'h11BB_33DD);

    wr(0, 4'd7, 32'h55, 4'hF); rd(1, 4'd7); step();
    chk("rd_first_old", rdata_a[1], 32'h0);
    rd(1, 4'd7); step();
    chk("rd_first_new", rdata_a[1], 32'h55);

    wr(0, 4'd0, 32'h100, 4'hF); step();
    wr(0, 4'd1, 32'h101, 4'hF); step();
    wr(0, 4'd2, 32'h102, 4'hF); step();
    rd(1, 4'd0); step();
    rd(1, 4'd1); step();
    rd(1, 4'd2); step();
    chk("lat3_seq0", rdata_b[1], 32'h100);
    step();
    chk("lat3_seq1", rdata_b[1], 32'h101);
    step();
    chk("lat3_seq2", rdata_b[1], 32'h102);
    step();
    chk("lat3_hold", rdata_b[1], 32'h102);

    wr(0, 4'd9, 32'h1, 4'hF); wr(1, 4'd9, 32'h2, 4'hF); step();
    rd(1, 4'd9); rd(0, 4'd9); step();
    chk("multi_wr_p1", rdata_a[1], 32'h2);
    chk("multi_wr_p0", rdata_a[0], 32'h2);

    wr(0, 4'd10, 32'hAAAA_AAAA, 4'hF); wr(1, 4'd10, 32'hBBBB_BBBB, 4'b0011); step();
    rd(0, 4'd10); step();
    chk("multi_lane", rdata_a[0], 32'hAAAA_BBBB);

    wr(0, 4'd13, 32'h77, 4'hF); step();
    rd(1, 4'd3); step();
    rd(1, 4'd13); step();
    chk("oor_rd_zero", rdata_a[1], 32'h0);

    step(); step();
    rd(1, 4'd3); step();
    rst = 1'b1;
    wr(0, 4'd3, 32'h99, 4'hF);
    step();
    rst = 1'b0;
    chk("rst_flush0", rdata_b[1], 32'h0);
    step();
    chk("rst_flush1", rdata_b[1], 32'h0);
    step();
    chk("rst_flush2", rdata_b[1], 32'h0);
    rd(1, 4'd3); rd(0, 4'd9); step();
    chk("rst_zeros_a", rdata_a[0], 32'h0);
    step(); step();
    chk("rst_keep_b", rdata_b[1], 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
